// File: rtl/cpu_boot_pkg.sv
// rtl/cpu_boot_pkg.sv - shared boot-loader types and constants
package cpu_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } boot_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_IMEM_DEPTH = 512;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - little-endian byte-to-word lane packer
module byte_packer
  import cpu_boot_pkg::*;
(
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          clr,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  output logic [BYTES_PER_WORD*8-1:0]   word,
  output logic                          word_valid
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0]            r_byte_idx;
  logic [BYTES_PER_WORD*8-1:0] r_word;

  // Drop each accepted byte into its lane; the index wraps naturally after the last lane.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      r_byte_idx <= '0;
      r_word     <= '0;
    end else if (byte_valid) begin
      r_word[r_byte_idx*8 +: 8] <= byte_data;
      r_byte_idx                <= r_byte_idx + IDX_W'(1);
    end
  end

  assign word       = r_word;
  assign word_valid = byte_valid && (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader streaming a word image into instruction memory (optional IMEM_LOADER_CHECKSUM_EN)
module imem_loader
  import cpu_boot_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int WI_W = $clog2(IMEM_DEPTH) + 1;

  boot_state_t                 r_state;
  boot_state_t                 w_next;
  logic [CNT_W-1:0]            r_count;
  logic [WI_W-1:0]             r_word_idx;
  logic                        w_xfer;
  logic                        w_clr;
  logic                        w_pk_valid;
  logic                        w_word_valid;
  logic [BYTES_PER_WORD*8-1:0] w_word;
  logic [CNT_W-1:0]            w_cnt_full;
  logic                        w_oversize;
  logic                        w_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]                  r_csum;
`endif

  // in_ready depends on state alone so the transfer term never loops back through the FSM.
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = (r_state == HDR0) || (r_state == HDR1) ||
                    (r_state == DATA) || (r_state == CHECK);
`else
  assign in_ready = (r_state == HDR0) || (r_state == HDR1) || (r_state == DATA);
`endif

  assign w_xfer     = in_valid && in_ready;
  assign w_cnt_full = CNT_W'({in_data, r_count[7:0]});
  assign w_oversize = 32'(w_cnt_full) > 32'(IMEM_DEPTH);
  assign w_last     = (CNT_W'(r_word_idx) + CNT_W'(1)) == r_count;
  assign ren_ext    = 1'b0;

  byte_packer u_packer (
    .clk        (clk),
    .srst       (srst),
    .clr        (w_clr),
    .byte_valid (w_pk_valid),
    .byte_data  (in_data),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus all state-driven outputs.
  always_comb begin
    w_next     = r_state;
    w_clr      = 1'b0;
    w_pk_valid = 1'b0;
    wen_ext    = 1'b0;
    addr_ext   = '0;
    wdata_ext  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_enable = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = HDR0;
          w_clr  = 1'b1;
        end
      end
      HDR0: begin
        busy = 1'b1;
        if (w_xfer) w_next = HDR1;
      end
      HDR1: begin
        busy = 1'b1;
        if (w_xfer) begin
          if (w_cnt_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_next = CHECK;
`else
            w_next = DONE;
`endif
          end else if (w_oversize) begin
            w_next = ERROR;
          end else begin
            w_next = DATA;
          end
        end
      end
      DATA: begin
        busy       = 1'b1;
        w_pk_valid = in_valid;
        if (w_word_valid) w_next = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        wen_ext   = 1'b1;
        addr_ext  = 32'({r_word_idx, 2'b00});
        wdata_ext = DATA_W'(w_word);
        if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = CHECK;
`else
          w_next = DONE;
`endif
        end else begin
          w_next = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        busy = 1'b1;
        if (w_xfer) w_next = (in_data == r_csum) ? DONE : ERROR;
      end
`endif
      DONE: begin
        done       = 1'b1;
        cpu_enable = 1'b1;
        if (start) begin
          w_next = HDR0;
          w_clr  = 1'b1;
        end
      end
      ERROR: begin
        error = 1'b1;
        if (start) begin
          w_next = HDR0;
          w_clr  = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Header count capture and word index advance.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_count    <= '0;
      r_word_idx <= '0;
    end else begin
      if (w_clr) begin
        r_count    <= '0;
        r_word_idx <= '0;
      end
      if (r_state == HDR0 && w_xfer) r_count[7:0] <= in_data;
      if (r_state == HDR1 && w_xfer) r_count      <= w_cnt_full;
      if (r_state == WRITE)          r_word_idx   <= r_word_idx + WI_W'(1);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over payload bytes only; the header never enters it.
  always_ff @(posedge clk) begin
    if (srst || w_clr) begin
      r_csum <= '0;
    end else if (r_state == DATA && w_xfer) begin
      r_csum <= r_csum ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        srst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        error;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_writes = 0;
  int          last_wen_cyc = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stream[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  imem_loader dut (
    .clk        (clk),
    .srst       (srst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .addr_ext   (addr_ext),
    .wen_ext    (wen_ext),
    .ren_ext    (ren_ext),
    .wdata_ext  (wdata_ext),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every write strobe pops the scoreboard.
  always @(negedge clk) begin
    logic [63:0] e;
    if (wen_ext) begin
      n_writes++;
      last_wen_cyc = cyc;
      check("in_ready_during_write", {31'b0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", addr_ext, wdata_ext);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", addr_ext, e[63:32]);
        check("write_data", wdata_ext, e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int k;
    in_data  = b;
    in_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout: got in_ready 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (gaps) tick();
  endtask

  task automatic send_stream(input bit gaps);
    foreach (stream[i]) send_byte(stream[i], gaps);
  endtask

  task automatic wait_end(output int c);
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (done || error) break;
      k++;
      if (k > 30) begin
        n_tests++;
        n_fail++;
        $display("FAIL end_timeout: got done 0 error 0 expected one set");
        break;
      end
    end
    c = cyc;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_wen"}, {31'b0, wen_ext}, 32'd0);
    check({tag, "_ren"}, {31'b0, ren_ext}, 32'd0);
    check({tag, "_addr"}, addr_ext, 32'd0);
    check({tag, "_wdata"}, wdata_ext, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_error"}, {31'b0, error}, 32'd0);
    check({tag, "_cpu_en"}, {31'b0, cpu_enable}, 32'd0);
  endtask

  task automatic load_two_word(input bit gaps);
    exp_q.push_back({32'h0000_0000, 32'h2000_0013});
    exp_q.push_back({32'h0000_0004, 32'h2401_0005});
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h05, 8'h00, 8'h01, 8'h24};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h13);
`endif
    send_stream(gaps);
  endtask

  initial begin
    int c;
    int w0;
    srst     = 1'b1;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    srst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Plain two-word load, in_valid held high.
    tick();
    w0 = n_writes;
    pulse_start();
    check("t1_busy", {31'b0, busy}, 32'd1);
    load_two_word(1'b0);
    wait_end(c);
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_cpu_en", {31'b0, cpu_enable}, 32'd1);
    check("t1_error", {31'b0, error}, 32'd0);
    check("t1_busy_end", {31'b0, busy}, 32'd0);
    check("t1_writes", n_writes - w0, 32'd2);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("t1_done_latency", c - last_wen_cyc, 32'd1);
`endif

    // Same image with a bubble after every byte; start from DONE drops cpu_enable.
    tick();
    w0 = n_writes;
    pulse_start();
    check("t2_cpu_en_drop", {31'b0, cpu_enable}, 32'd0);
    check("t2_done_drop", {31'b0, done}, 32'd0);
    load_two_word(1'b1);
    wait_end(c);
    check("t2_done", {31'b0, done}, 32'd1);
    check("t2_cpu_en", {31'b0, cpu_enable}, 32'd1);
    check("t2_writes", n_writes - w0, 32'd2);

    // Zero-length image.
    tick();
    w0 = n_writes;
    pulse_start();
    stream = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    send_stream(1'b0);
    wait_end(c);
    check("t3_done", {31'b0, done}, 32'd1);
    check("t3_cpu_en", {31'b0, cpu_enable}, 32'd1);
    check("t3_writes", n_writes - w0, 32'd0);

    // Oversize count 513, then recovery.
    tick();
    w0 = n_writes;
    pulse_start();
    stream = '{8'h01, 8'h02};
    send_stream(1'b0);
    wait_end(c);
    check("t4_error", {31'b0, error}, 32'd1);
    check("t4_done", {31'b0, done}, 32'd0);
    check("t4_cpu_en", {31'b0, cpu_enable}, 32'd0);
    check("t4_in_ready", {31'b0, in_ready}, 32'd0);
    check("t4_writes", n_writes - w0, 32'd0);
    tick();
    pulse_start();
    check("t4_error_clr", {31'b0, error}, 32'd0);
    load_two_word(1'b0);
    wait_end(c);
    check("t4_recover_done", {31'b0, done}, 32'd1);
    check("t4_recover_error", {31'b0, error}, 32'd0);

    // Reset after two payload bytes, then a clean reload.
    tick();
    w0 = n_writes;
    pulse_start();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00};
    send_stream(1'b0);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t5_reset");
    check("t5_writes", n_writes - w0, 32'd0);
    tick();
    pulse_start();
    load_two_word(1'b0);
    wait_end(c);
    check("t5_done", {31'b0, done}, 32'd1);
    check("t5_cpu_en", {31'b0, cpu_enable}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good: 11^22^33^44 = 44.
    tick();
    exp_q.push_back({32'h0000_0000, 32'h4433_2211});
    pulse_start();
    stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_stream(1'b0);
    wait_end(c);
    check("t6_done", {31'b0, done}, 32'd1);
    check("t6_error", {31'b0, error}, 32'd0);

    // Checksum bad trailer.
    tick();
    exp_q.push_back({32'h0000_0000, 32'h4433_2211});
    pulse_start();
    stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_stream(1'b0);
    wait_end(c);
    check("t7_error", {31'b0, error}, 32'd1);
    check("t7_cpu_en", {31'b0, cpu_enable}, 32'd0);
`endif

    tick();
    tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
